mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between the two requesters; 0 = fixed priority, mem side wins ties.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 fetch_request_enable  in  1  one-cycle request pulse, fetch side.
REQ-005 freq_mode, freq_addr, freq_wdata, freq_wstrb  in  1/32/32/4  fetch request fields, valid with the pulse; mode 1 = write.
REQ-006 fetch_response_enable  out  1  one-cycle response pulse, fetch side.
REQ-007 fresp_data  out  32  fetch response data.
REQ-008 mem_request_enable  in  1  one-cycle request pulse, mem side.
REQ-009 mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb  in  1/32/32/4  mem request fields, valid with the pulse.
REQ-010 mem_response_enable  out  1  one-cycle response pulse, mem side.
REQ-011 mresp_data  out  32  mem response data.
REQ-012 request_enable  out  1  one-cycle pulse to the shared downstream port.
REQ-013 req_mode, req_addr, req_wdata, req_wstrb  out  1/32/32/4  downstream request fields.
REQ-014 response_enable  in  1  one-cycle downstream completion pulse.
REQ-015 resp_data  in  32  downstream data, valid with response_enable.
REQ-016 busy  out  1  high when state is WAIT or either port has a pending request.

Function
REQ-017 Each port SHALL have a pending flag and capture registers; a request pulse SHALL capture mode/addr/wdata/wstrb and set pending on that edge.
REQ-018 A request pulse on a port that is already pending or in flight SHALL be dropped; captured fields and pending stay unchanged.
REQ-019 FSM SHALL have two states: IDLE and WAIT; at most one downstream request is outstanding.
REQ-020 IDLE, no pending: stay IDLE; request_enable low.
REQ-021 IDLE, one pending: issue that port on the next edge: request_enable high for exactly one cycle; req_* = captured fields; clear pending; record grant owner; go to WAIT.
REQ-022 IDLE, both pending, RR_EN=1: grant the port not granted last; RR_EN=0: grant mem.
REQ-023 Issue latency: a pulse sampled at edge N SHALL produce request_enable during the cycle after edge N+1 at the earliest; pending is not bypassed.
REQ-024 req_* outputs SHALL hold the last issued values between pulses.
REQ-025 WAIT: on the edge sampling response_enable=1, latch resp_data into fresp_data or mresp_data per grant owner; assert that port's response pulse for one cycle; go to IDLE.
REQ-026 The next pending request SHALL issue on the edge after the return to IDLE, giving a one-cycle gap between consecutive request_enable pulses.
REQ-027 fresp_data and mresp_data SHALL hold until that port's next response; the other port's data is never modified.
REQ-028 response_enable sampled in IDLE SHALL be ignored: no response pulse, no data change.
REQ-029 The granted port stays in flight until its response pulse; a new pulse on that port in the same cycle as its response pulse is accepted.
REQ-030 A request on the other port during WAIT SHALL be captured and issued after the return to IDLE.

Reset
REQ-031 rstn low SHALL immediately force all outputs to 0, clear both pending flags and all capture/data registers, set state IDLE, and set last-grant = fetch.
REQ-032 Reset mid-transaction SHALL discard in-flight and pending requests; a downstream response arriving after reset release SHALL be ignored (REQ-028).

Verification
REQ-033 Fetch read addr 0x1000 -> one request_enable, req_addr=0x1000, req_mode=0; resp_data=0xDEADBEEF -> fetch_response_enable one cycle, fresp_data=0xDEADBEEF, mresp_data unchanged.
REQ-034 Fetch and mem pulse same cycle, RR_EN=1, after reset -> mem issued first, then fetch; a second simultaneous pair -> fetch first.
REQ-035 RR_EN=0, both pending repeatedly -> mem always wins; fetch issues only when mem is not pending.
REQ-036 Mem write addr 0x80, wdata 0x12345678, wstrb 0xF, issued; fetch pulse during WAIT -> fetch issued one cycle after mem response pulse; fields match captures.
REQ-037 Second fetch pulse while fetch in flight -> dropped; exactly one request_enable and one response pulse.
REQ-038 rstn low during WAIT, then release and response_enable pulse -> no response pulses; all outputs 0; busy 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port request arbiter in front of a single downstream memory port.
// One transaction outstanding at a time; fetch and mem requests are captured and issued in turn.
module mem_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        request_enable,
  output logic        req_mode,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        response_enable,
  input  logic [31:0] resp_data,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t      state_r, state_nx;
  logic        f_pend_r, f_pend_nx, m_pend_r, m_pend_nx;
  req_t        f_cap_r, f_cap_nx, m_cap_r, m_cap_nx, req_r, req_nx;
  logic        owner_mem_r, owner_mem_nx;
  logic        rr_mem_r, rr_mem_nx;
  logic        req_en_r, req_en_nx;
  logic        f_rsp_en_r, f_rsp_en_nx, m_rsp_en_r, m_rsp_en_nx;
  logic [31:0] f_rsp_r, f_rsp_nx, m_rsp_r, m_rsp_nx;
  logic        busy_r, busy_nx;
  logic        grant_mem_s, f_inflight_s, m_inflight_s;

  // Arbitration choice; the round-robin pointer only moves on contested grants.
  always_comb begin
    grant_mem_s = 1'b0;
    if (f_pend_r && m_pend_r) begin
      if (RR_EN != 0) begin
        grant_mem_s = ~rr_mem_r;
      end else begin
        grant_mem_s = 1'b1;
      end
    end else begin
      grant_mem_s = m_pend_r;
    end
  end

  assign f_inflight_s = (state_r == WAIT) && !owner_mem_r;
  assign m_inflight_s = (state_r == WAIT) &&  owner_mem_r;

  // Next-state, issue, response routing and request capture.
  always_comb begin
    state_nx     = state_r;
    f_pend_nx    = f_pend_r;
    m_pend_nx    = m_pend_r;
    f_cap_nx     = f_cap_r;
    m_cap_nx     = m_cap_r;
    req_nx       = req_r;
    owner_mem_nx = owner_mem_r;
    rr_mem_nx    = rr_mem_r;
    req_en_nx    = 1'b0;
    f_rsp_en_nx  = 1'b0;
    m_rsp_en_nx  = 1'b0;
    f_rsp_nx     = f_rsp_r;
    m_rsp_nx     = m_rsp_r;
    case (state_r)
      IDLE: begin
        if (f_pend_r || m_pend_r) begin
          req_en_nx    = 1'b1;
          state_nx     = WAIT;
          owner_mem_nx = grant_mem_s;
          if (f_pend_r && m_pend_r) begin
            rr_mem_nx = grant_mem_s;
          end else begin
            rr_mem_nx = rr_mem_r;
          end
          if (grant_mem_s) begin
            req_nx    = m_cap_r;
            m_pend_nx = 1'b0;
          end else begin
            req_nx    = f_cap_r;
            f_pend_nx = 1'b0;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (response_enable) begin
          state_nx = IDLE;
          if (owner_mem_r) begin
            m_rsp_nx    = resp_data;
            m_rsp_en_nx = 1'b1;
          end else begin
            f_rsp_nx    = resp_data;
            f_rsp_en_nx = 1'b1;
          end
        end else begin
          state_nx = WAIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // A port that is pending or in flight ignores new pulses.
    if (fetch_request_enable && !f_pend_r && !f_inflight_s) begin
      f_pend_nx = 1'b1;
      f_cap_nx  = '{mode: freq_mode, addr: freq_addr, wdata: freq_wdata, wstrb: freq_wstrb};
    end else begin
      f_cap_nx = f_cap_r;
    end
    if (mem_request_enable && !m_pend_r && !m_inflight_s) begin
      m_pend_nx = 1'b1;
      m_cap_nx  = '{mode: mreq_mode, addr: mreq_addr, wdata: mreq_wdata, wstrb: mreq_wstrb};
    end else begin
      m_cap_nx = m_cap_r;
    end

    busy_nx = (state_nx == WAIT) || f_pend_nx || m_pend_nx;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      f_pend_r    <= 1'b0;
      m_pend_r    <= 1'b0;
      f_cap_r     <= '0;
      m_cap_r     <= '0;
      req_r       <= '0;
      owner_mem_r <= 1'b0;
      rr_mem_r    <= 1'b0;
      req_en_r    <= 1'b0;
      f_rsp_en_r  <= 1'b0;
      m_rsp_en_r  <= 1'b0;
      f_rsp_r     <= 32'h0000_0000;
      m_rsp_r     <= 32'h0000_0000;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      f_pend_r    <= f_pend_nx;
      m_pend_r    <= m_pend_nx;
      f_cap_r     <= f_cap_nx;
      m_cap_r     <= m_cap_nx;
      req_r       <= req_nx;
      owner_mem_r <= owner_mem_nx;
      rr_mem_r    <= rr_mem_nx;
      req_en_r    <= req_en_nx;
      f_rsp_en_r  <= f_rsp_en_nx;
      m_rsp_en_r  <= m_rsp_en_nx;
      f_rsp_r     <= f_rsp_nx;
      m_rsp_r     <= m_rsp_nx;
      busy_r      <= busy_nx;
    end
  end

  assign request_enable        = req_en_r;
  assign req_mode              = req_r.mode;
  assign req_addr              = req_r.addr;
  assign req_wdata             = req_r.wdata;
  assign req_wstrb             = req_r.wstrb;
  assign fetch_response_enable = f_rsp_en_r;
  assign fresp_data            = f_rsp_r;
  assign mem_response_enable   = m_rsp_en_r;
  assign mresp_data            = m_rsp_r;
  assign busy                  = busy_r;

endmodule
